vreg_bus_ctrl: RTL and testbench
================================

VREG_BUS_CTRL -- requirements
Module: vreg_bus_ctrl

Interface
REQ-001 Parameter NREG, default 8: number of vector registers sharing the vector bus; NREG SHALL be at least 2.
REQ-002 Parameter IDXW, default $clog2(NREG): register index width.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports req_valid[1:0], input, 2: command valid, one bit per requester (0 = host, 1 = ALU).
REQ-006 Ports req_ready[1:0], output, 2: command accepted when valid and ready are both high.
REQ-007 Ports req_op[1:0], input, 2x2: per-requester opcode; 00 = WR, 01 = RD, 10 = MOV, 11 = illegal.
REQ-008 Ports req_src[1:0] and req_dst[1:0], input, 2xIDXW: per-requester source and destination register index.
REQ-009 Port reg_set, output, NREG: load strobe to each vector register.
REQ-010 Port reg_en, output, NREG: tri-state bus-drive enable to each vector register.
REQ-011 Port ext_drive, output, 2: requester n drives the bus (WR).
REQ-012 Port ext_capture, output, 2: requester n samples the bus (RD).
REQ-013 Ports done, output, 1; done_id, output, 1; err, output, 1: completion pulse, completing requester, error flag.
REQ-014 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, and TURN; transitions SHALL be IDLE->DRIVE on handshake, DRIVE->TURN unconditionally, and TURN->IDLE unconditionally.
REQ-016 In IDLE, req_ready SHALL be one-hot to the granted valid requester and zero in all other states.
REQ-017 Arbitration SHALL be round-robin: on simultaneous valids, the requester not served last wins; a lone valid requester SHALL always be granted.
REQ-018 On handshake, the controller SHALL register op, src, dst, and id.
REQ-019 In DRIVE, for exactly one cycle, outputs SHALL be as follows: WR gives reg_set[dst] and ext_drive[id]; RD gives reg_en[src] and ext_capture[id]; MOV gives reg_en[src] and reg_set[dst].
REQ-020 In DRIVE, done SHALL pulse with done_id = id.
REQ-021 An illegal op, or any used index >= NREG, SHALL assert err with done, with all reg_set, reg_en, ext_drive, and ext_capture low.
REQ-022 A MOV with src == dst SHALL be legal and SHALL assert reg_en[src] and reg_set[src] together.
REQ-023 At most one reg_en bit or ext_drive bit SHALL be high in any cycle (no bus contention).
REQ-024 TURN SHALL deassert all drive and strobe outputs (bus turnaround cycle).
REQ-025 Command-to-DRIVE latency SHALL be 1 cycle, and throughput SHALL be one command per 3 cycles.
REQ-026 All outputs SHALL be registered or decoded solely from registered state (no combinational valid->strobe path), except req_ready, which SHALL derive from IDLE state and req_valid.
REQ-027 A requester holding valid high with changing payload while not ready SHALL NOT affect the controller.

Reset
REQ-028 On rst_n low, the controller SHALL immediately enter IDLE, drive all outputs to 0, and set the round-robin pointer to favour requester 0.
REQ-029 Reset asserted during DRIVE SHALL abort the command with no done pulse; the command SHALL NOT be replayed.
REQ-030 The first edge after rst_n rises SHALL allow a handshake.

Structure
REQ-031 A shared package vreg_pkg SHALL hold the opcode enum (OP_WR, OP_RD, OP_MOV, OP_ILL), the FSM state enum, and the requester-id constants.
REQ-032 The round-robin grant SHALL be a separate sub-module rr_arb2 (inputs req[1:0], advance; output gnt[1:0]; pointer flop with async reset).

Verification
REQ-033 Host WR dst=3 -> ready at cycle 0, reg_set=0x08 and ext_drive=01 at cycle 1, done with done_id=0, idle at cycle 3.
REQ-034 Both requesters valid after reset with MOV 2->5 (host) and RD 7 (ALU) -> host served first, reg_en=0x04 with reg_set=0x20, TURN, then ALU reg_en=0x80 with ext_capture=10.
REQ-035 ALU held valid continuously with the host issuing back-to-back -> grants alternate 0,1,0,1 and no starvation.
REQ-036 op=11, or src=9 with NREG=8 -> done=1, err=1, all strobes 0.
REQ-037 rst_n pulled low during DRIVE of MOV 1->4 -> reg_en and reg_set go to 0 asynchronously, no done, next grant goes to host.
REQ-038 Random traffic with assertions -> reg_en/ext_drive onehot0 every cycle and a strobe-free TURN after every DRIVE.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared types and constants for the vector-register bus controller.
package vreg_pkg;

    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RD  = 2'b01,
        OP_MOV = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StDrive = 2'b01,
        StTurn  = 2'b10
    } state_e;

    localparam logic ID_HOST = 1'b0;
    localparam logic ID_ALU  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not served last wins a tie.
module rr_arb2
    import vreg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Requester that wins when both request.
    logic r_prio;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_prio == ID_HOST) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= ID_HOST;
        end else if (advance) begin
            r_prio <= ~gnt[1];
        end
    end

endmodule

// File: rtl/vreg_bus_ctrl.sv
// Shared vector-bus controller: arbitrates host/ALU commands and sequences
// a one-cycle DRIVE followed by a strobe-free TURN cycle.
module vreg_bus_ctrl
    import vreg_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned IDXW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [3:0]        req_op,
    input  logic [2*IDXW-1:0] req_src,
    input  logic [2*IDXW-1:0] req_dst,
    output logic [NREG-1:0]   reg_set,
    output logic [NREG-1:0]   reg_en,
    output logic [1:0]        ext_drive,
    output logic [1:0]        ext_capture,
    output logic              done,
    output logic              done_id,
    output logic              err,
    output logic              busy
);

    state_e            r_state, w_state_next;
    op_e               r_op;
    logic [IDXW-1:0]   r_src, r_dst;
    logic              r_id;
    logic [1:0]        w_gnt;
    logic              w_idle, w_hs, w_win;
    logic              w_src_ok, w_dst_ok, w_err;
    logic [NREG-1:0]   w_src_dec, w_dst_dec;

    assign w_idle    = (r_state == StIdle);
    assign req_ready = w_idle ? w_gnt : 2'b00;
    assign w_hs      = |req_ready;
    assign w_win     = req_ready[1];

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (w_hs),
        .gnt     (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_hs) w_state_next = StDrive;
            StDrive: w_state_next = StTurn;
            StTurn:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Payload is captured only on handshake, so a waiting requester may churn freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= OP_WR;
            r_src <= '0;
            r_dst <= '0;
            r_id  <= ID_HOST;
        end else if (w_hs) begin
            r_op  <= op_e'(w_win ? req_op[3:2] : req_op[1:0]);
            r_src <= w_win ? req_src[2*IDXW-1:IDXW] : req_src[IDXW-1:0];
            r_dst <= w_win ? req_dst[2*IDXW-1:IDXW] : req_dst[IDXW-1:0];
            r_id  <= w_win;
        end
    end

    assign w_src_ok  = 32'(r_src) < NREG;
    assign w_dst_ok  = 32'(r_dst) < NREG;
    assign w_src_dec = NREG'(1) << r_src;
    assign w_dst_dec = NREG'(1) << r_dst;

    always_comb begin
        case (r_op)
            OP_WR:   w_err = !w_dst_ok;
            OP_RD:   w_err = !w_src_ok;
            OP_MOV:  w_err = !(w_src_ok && w_dst_ok);
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        reg_set     = '0;
        reg_en      = '0;
        ext_drive   = 2'b00;
        ext_capture = 2'b00;
        done        = 1'b0;
        done_id     = 1'b0;
        err         = 1'b0;
        busy        = !w_idle;
        if (r_state == StDrive) begin
            done    = 1'b1;
            done_id = r_id;
            err     = w_err;
            if (!w_err) begin
                case (r_op)
                    OP_WR: begin
                        reg_set         = w_dst_dec;
                        ext_drive[r_id] = 1'b1;
                    end
                    OP_RD: begin
                        reg_en            = w_src_dec;
                        ext_capture[r_id] = 1'b1;
                    end
                    OP_MOV: begin
                        reg_en  = w_src_dec;
                        reg_set = w_dst_dec;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vreg_bus_ctrl.sv
// Scoreboard bench for vreg_bus_ctrl: a cycle-level reference model predicts
// grants and DRIVE responses; a monitor pops and compares them as they appear.
module tb_vreg_bus_ctrl;

    localparam int unsigned NREG = 8;
    localparam int unsigned IDXW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready;
    logic [3:0] req_op;
    logic [7:0] req_src, req_dst;
    logic [7:0] reg_set, reg_en;
    logic [1:0] ext_drive, ext_capture;
    logic       done, done_id, err, busy;

    vreg_bus_ctrl #(.NREG(NREG), .IDXW(IDXW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .reg_set     (reg_set),
        .reg_en      (reg_en),
        .ext_drive   (ext_drive),
        .ext_capture (ext_capture),
        .done        (done),
        .done_id     (done_id),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [21:0] resp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_hs = -100;
    logic last_id = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response as {done_id, err, reg_set, reg_en, ext_drive, ext_capture}.
    function automatic logic [21:0] expect_resp(input logic id, input logic [1:0] op,
                                                input logic [3:0] src, input logic [3:0] dst);
        logic [7:0] set, en;
        logic [1:0] drv, cap;
        logic       e;
        logic       src_ok, dst_ok;
        set = '0; en = '0; drv = '0; cap = '0;
        src_ok = 32'(src) < NREG;
        dst_ok = 32'(dst) < NREG;
        case (op)
            2'd0:    e = !dst_ok;
            2'd1:    e = !src_ok;
            2'd2:    e = !(src_ok && dst_ok);
            default: e = 1'b1;
        endcase
        if (!e) begin
            if (op == 2'd0) begin set[dst[2:0]] = 1'b1; drv[id] = 1'b1; end
            if (op == 2'd1) begin en[src[2:0]]  = 1'b1; cap[id] = 1'b1; end
            if (op == 2'd2) begin en[src[2:0]]  = 1'b1; set[dst[2:0]] = 1'b1; end
        end
        return {id, e, set, en, drv, cap};
    endfunction

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic step(input logic [1:0] v, input logic [3:0] op, input logic [7:0] src,
                        input logic [7:0] dst, output logic [1:0] acc, output logic [1:0] act);
        logic       idle;
        logic [1:0] exp_rdy;
        logic       id;
        req_valid = v;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        @(negedge clk);
        idle    = (cyc - last_hs) >= 3;
        exp_rdy = 2'b00;
        if (idle) begin
            if (v == 2'b01)      exp_rdy = 2'b01;
            else if (v == 2'b10) exp_rdy = 2'b10;
            else if (v == 2'b11) exp_rdy = last_id ? 2'b01 : 2'b10;
        end
        act = req_ready;
        check("ready", 64'(req_ready), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(!idle));
        if (exp_rdy != 2'b00) begin
            id = exp_rdy[1];
            sb.push_back('{at: cyc + 1,
                           resp: expect_resp(id, id ? op[3:2] : op[1:0],
                                             id ? src[7:4] : src[3:0],
                                             id ? dst[7:4] : dst[3:0])});
            last_hs = cyc;
            last_id = id;
        end
        acc = exp_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        logic [1:0] acc, act;
        repeat (n) step(2'b00, 4'h0, 8'h00, 8'h00, acc, act);
    endtask

    task automatic serve(input logic [1:0] want, input logic [3:0] op, input logic [7:0] src,
                         input logic [7:0] dst);
        logic [1:0] pend, acc, act;
        pend = want;
        for (int i = 0; i < 12 && pend != 2'b00; i++) begin
            step(pend, op, src, dst, acc, act);
            pend = pend & ~acc;
        end
        idle_cycles(3);
    endtask

    task automatic model_reset();
        sb.delete();
        last_hs = -100;
        last_id = 1'b1;
    endtask

    task automatic reset_dut(input int hold);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        model_reset();
        repeat (hold) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compares every DRIVE response and the bus invariants each cycle.
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            check("en_onehot0", 64'($countones(reg_en) <= 1), 64'(1));
            check("drive_onehot0", 64'($countones(ext_drive) <= 1), 64'(1));
            if (prev_done)
                check("turn", 64'({busy, done, reg_set, reg_en, ext_drive, ext_capture}),
                      64'({1'b1, 21'd0}));
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'({done, done_id, err}), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("latency", 64'(cyc), 64'(e.at));
                    check("resp", 64'({done_id, err, reg_set, reg_en, ext_drive, ext_capture}),
                          64'(e.resp));
                end
            end else begin
                check("quiet", 64'({reg_set, reg_en, ext_drive, ext_capture, err, done_id}),
                      64'(0));
            end
            prev_done = done;
        end
    end

    initial begin
        logic [1:0] acc, act, pend;
        logic [1:0] p_op [2];
        logic [3:0] p_src[2];
        logic [3:0] p_dst[2];
        logic [3:0] op;
        logic [7:0] src, dst;
        int         hg, ag, grants;

        rst_n = 1'b0; req_valid = 2'b00; req_op = '0; req_src = '0; req_dst = '0;
        @(negedge clk);
        check("reset_outputs", 64'({req_ready, reg_set, reg_en, ext_drive, ext_capture,
                                    done, done_id, err, busy}), 64'(0));
        @(posedge clk);
        #1;
        reset_dut(2);

        // Host WR dst=3 on the first edge after reset release.
        serve(2'b01, 4'b0000, 8'h00, 8'h03);

        // Simultaneous host MOV 2->5 and ALU RD 7 right after reset.
        reset_dut(2);
        serve(2'b11, {2'b01, 2'b10}, {4'd7, 4'd2}, {4'd0, 4'd5});

        // Both held valid: grants must alternate.
        hg = 0; ag = 0; grants = 0;
        for (int i = 0; i < 60 && grants < 12; i++) begin
            op  = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            src = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            dst = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            step(2'b11, op, src, dst, acc, act);
            if (acc != 2'b00) grants++;
            hg += int'(act[0]);
            ag += int'(act[1]);
        end
        check("host_grants", 64'(hg), 64'(6));
        check("alu_grants", 64'(ag), 64'(6));
        idle_cycles(3);

        // Errors: illegal op, src out of range, dst out of range; MOV onto itself.
        serve(2'b11, {2'b01, 2'b11}, {4'd9, 4'd0}, {4'd0, 4'd2});
        serve(2'b10, 4'b0000, 8'h00, {4'd12, 4'd0});
        serve(2'b01, 4'b0010, 8'h06, 8'h06);

        // Reset during DRIVE of host MOV 1->4: abort, no replay, host favoured again.
        reset_dut(2);
        step(2'b01, 4'b0010, 8'h01, 8'h04, acc, act);
        #1;
        check("mid_drive_en", 64'(reg_en), 64'(8'h02));
        check("mid_drive_set", 64'(reg_set), 64'(8'h10));
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_outputs", 64'({reg_en, reg_set, done, busy}), 64'(0));
        reset_dut(1);
        serve(2'b11, {2'b01, 2'b00}, 8'h00, 8'h01);

        // Random traffic with payload churn while waiting.
        pend = 2'b00;
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if ((!pend[r] && $urandom_range(0, 2) != 0) ||
                    (pend[r] && $urandom_range(0, 3) == 0)) begin
                    pend[r]  = 1'b1;
                    p_op[r]  = 2'($urandom_range(0, 3));
                    p_src[r] = 4'($urandom_range(0, 9));
                    p_dst[r] = 4'($urandom_range(0, 9));
                end
            end
            step(pend, {p_op[1], p_op[0]}, {p_src[1], p_src[0]}, {p_dst[1], p_dst[0]},
                 acc, act);
            pend = pend & ~acc;
        end
        idle_cycles(4);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
